// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and reservation signals of the multi-port register file
interface regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RA, RB;
  logic [DATA_W-1:0] BusA, BusB;
  logic              BusyA, BusyB;
  logic              RegWr0, RegWr1;
  logic [ADDR_W-1:0] RW0, RW1;
  logic [DATA_W-1:0] BusW0, BusW1;
  logic              Rsv;
  logic [ADDR_W-1:0] RsvAddr;
  logic              RsvOk;

  modport master (
    output RA, RB, RegWr0, RegWr1, RW0, RW1, BusW0, BusW1, Rsv, RsvAddr,
    input  BusA, BusB, BusyA, BusyB, RsvOk
  );

  modport slave (
    input  RA, RB, RegWr0, RegWr1, RW0, RW1, BusW0, BusW1, Rsv, RsvAddr,
    output BusA, BusB, BusyA, BusyB, RsvOk
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2R/2W register file with hardwired zero register and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 2**ADDR_W-1
) (
  input logic         Clk,
  input logic         Rst_n,
  regfile_mp_if.slave rf
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] zeroAddr = ZERO_REG[ADDR_W-1:0];

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              we0, we1;

  // Writes to the zero register are dropped, and nothing commits while reset is held.
  assign we0 = Rst_n && rf.RegWr0 && rf.RW0 != zeroAddr;
  assign we1 = Rst_n && rf.RegWr1 && rf.RW1 != zeroAddr;

  // Read muxes, reservation grant and busy lookups are all combinational.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    rf.BusA = rf.RA == zeroAddr ? '0 :
              (we1 && rf.RW1 == rf.RA) ? rf.BusW1 :
              (we0 && rf.RW0 == rf.RA) ? rf.BusW0 : regs[rf.RA];
    rf.BusB = rf.RB == zeroAddr ? '0 :
              (we1 && rf.RW1 == rf.RB) ? rf.BusW1 :
              (we0 && rf.RW0 == rf.RB) ? rf.BusW0 : regs[rf.RB];
`else
    rf.BusA = rf.RA == zeroAddr ? '0 : regs[rf.RA];
    rf.BusB = rf.RB == zeroAddr ? '0 : regs[rf.RB];
`endif
    rf.BusyA = busy[rf.RA];
    rf.BusyB = busy[rf.RB];
    rf.RsvOk = rf.Rsv && !busy[rf.RsvAddr] && rf.RsvAddr != zeroAddr;
  end

  // Register storage; port 1 is written last so it wins an address collision.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      regs <= '{default: '0};
    end else begin
      if (we0) regs[rf.RW0] <= rf.BusW0;
      if (we1) regs[rf.RW1] <= rf.BusW1;
    end
  end

  // Scoreboard: committed writes retire a reservation, a granted reserve sets it last so it wins.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busy <= '0;
    end else begin
      if (we0) busy[rf.RW0] <= 1'b0;
      if (we1) busy[rf.RW1] <= 1'b0;
      if (rf.RsvOk) busy[rf.RsvAddr] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard-driven bench for regfile_mp (64x32 default plus a 32-bit/16-entry sweep)
module tb_regfile_mp;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [63:0] expQ [$];

  typedef struct {
    logic [31:0] a, b;
    logic        ba, bb, ok;
  } exp_t;
  exp_t swQ [$];

  regfile_mp_if #(.DATA_W(64), .ADDR_W(5)) bus ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(4)) bus2 ();

  regfile_mp dut (.Clk(Clk), .Rst_n(Rst_n), .rf(bus));
  regfile_mp #(.DATA_W(32), .ADDR_W(4)) dut2 (.Clk(Clk), .Rst_n(Rst_n), .rf(bus2));

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic idle;
    bus.RA = '0; bus.RB = '0; bus.RegWr0 = 0; bus.RegWr1 = 0;
    bus.RW0 = '0; bus.RW1 = '0; bus.BusW0 = '0; bus.BusW1 = '0;
    bus.Rsv = 0; bus.RsvAddr = '0;
    bus2.RA = '0; bus2.RB = '0; bus2.RegWr0 = 0; bus2.RegWr1 = 0;
    bus2.RW0 = '0; bus2.RW1 = '0; bus2.BusW0 = '0; bus2.BusW1 = '0;
    bus2.Rsv = 0; bus2.RsvAddr = '0;
  endtask

  task automatic test_reset;
    logic [63:0] e;
    idle();
    bus.Rsv = 1; bus.RsvAddr = 5'd3;
    #1;
    expQ.push_back(64'd0);
    e = expQ.pop_front(); total++;
    if (bus.BusA !== e) begin bad++; $display("FAIL reset_busa got=%h want=%h", bus.BusA, e); end
    total++;
    if (bus.BusyA !== 1'b0) begin bad++; $display("FAIL reset_busya got=%b want=0", bus.BusyA); end
    total++;
    if (bus.RsvOk !== 1'b1) begin bad++; $display("FAIL reset_rsvok got=%b want=1", bus.RsvOk); end
    @(negedge Clk) Rst_n = 1; idle();
    @(negedge Clk);
    bus.RegWr0 = 1; bus.RW0 = 5'd3; bus.BusW0 = 64'hDEAD; bus.Rsv = 1; bus.RsvAddr = 5'd3;
    expQ.push_back(64'hDEAD);
    @(negedge Clk) idle(); bus.RA = 5'd3; #1;
    e = expQ.pop_front(); total++;
    if (bus.BusA !== e) begin bad++; $display("FAIL pre_reset_write got=%h want=%h", bus.BusA, e); end
    total++;
    if (bus.BusyA !== 1'b1) begin bad++; $display("FAIL pre_reset_busy got=%b want=1", bus.BusyA); end
    bus.RegWr0 = 1; bus.RW0 = 5'd3; bus.BusW0 = 64'hBEEF;
    #1 Rst_n = 0; #1;
    expQ.push_back(64'd0);
    expQ.push_back(64'd0);
    e = expQ.pop_front(); total++;
    if (bus.BusA !== e) begin bad++; $display("FAIL async_reset_busa got=%h want=%h", bus.BusA, e); end
    total++;
    if (bus.BusyA !== 1'b0) begin bad++; $display("FAIL async_reset_busya got=%b want=0", bus.BusyA); end
    @(posedge Clk) #1;
    e = expQ.pop_front(); total++;
    if (bus.BusA !== e) begin bad++; $display("FAIL write_in_reset got=%h want=%h", bus.BusA, e); end
    @(negedge Clk) Rst_n = 1; idle();
  endtask

  task automatic test_zero_reg;
    logic [63:0] e;
    @(negedge Clk) bus.RegWr0 = 1; bus.RW0 = 5'd31; bus.BusW0 = 64'h1234;
    expQ.push_back(64'd0);
    @(negedge Clk) idle(); bus.RA = 5'd31; bus.Rsv = 1; bus.RsvAddr = 5'd31; #1;
    e = expQ.pop_front(); total++;
    if (bus.BusA !== e) begin bad++; $display("FAIL zero_read got=%h want=%h", bus.BusA, e); end
    total++;
    if (bus.RsvOk !== 1'b0) begin bad++; $display("FAIL zero_rsvok got=%b want=0", bus.RsvOk); end
    @(negedge Clk) idle(); #1;
    total++;
    if (bus.BusyA !== 1'b0 && bus.RA == 5'd0) begin bad++; $display("FAIL zero_busy got=%b want=0", bus.BusyA); end
    bus.RA = 5'd31; #1;
    total++;
    if (bus.BusyA !== 1'b0) begin bad++; $display("FAIL zero_busy31 got=%b want=0", bus.BusyA); end
  endtask

  task automatic test_dual_write;
    logic [63:0] e;
    @(negedge Clk) idle();
    bus.RegWr0 = 1; bus.RW0 = 5'd5; bus.BusW0 = 64'h11;
    bus.RegWr1 = 1; bus.RW1 = 5'd6; bus.BusW1 = 64'h22;
    expQ.push_back(64'h11); expQ.push_back(64'h22);
    @(negedge Clk) idle(); bus.RA = 5'd5; bus.RB = 5'd6; #1;
    e = expQ.pop_front(); total++;
    if (bus.BusA !== e) begin bad++; $display("FAIL dual_r5 got=%h want=%h", bus.BusA, e); end
    e = expQ.pop_front(); total++;
    if (bus.BusB !== e) begin bad++; $display("FAIL dual_r6 got=%h want=%h", bus.BusB, e); end
  endtask

  task automatic test_collision;
    logic [63:0] e;
    @(negedge Clk) idle();
    bus.RegWr0 = 1; bus.RW0 = 5'd7; bus.BusW0 = 64'hAA;
    bus.RegWr1 = 1; bus.RW1 = 5'd7; bus.BusW1 = 64'hBB;
    expQ.push_back(64'hBB);
    @(negedge Clk) idle(); bus.RB = 5'd7; #1;
    e = expQ.pop_front(); total++;
    if (bus.BusB !== e) begin bad++; $display("FAIL collision_r7 got=%h want=%h", bus.BusB, e); end
  endtask

  task automatic test_scoreboard;
    logic [63:0] e;
    @(negedge Clk) idle(); bus.Rsv = 1; bus.RsvAddr = 5'd9; #1;
    total++;
    if (bus.RsvOk !== 1'b1) begin bad++; $display("FAIL rsv_grant got=%b want=1", bus.RsvOk); end
    @(negedge Clk) idle(); bus.RA = 5'd9; bus.Rsv = 1; bus.RsvAddr = 5'd9; #1;
    total++;
    if (bus.BusyA !== 1'b1) begin bad++; $display("FAIL rsv_busy got=%b want=1", bus.BusyA); end
    total++;
    if (bus.RsvOk !== 1'b0) begin bad++; $display("FAIL rsv_again got=%b want=0", bus.RsvOk); end
    @(negedge Clk) idle(); bus.RegWr1 = 1; bus.RW1 = 5'd9; bus.BusW1 = 64'h5;
    expQ.push_back(64'h5);
    @(negedge Clk) idle(); bus.RA = 5'd9; #1;
    e = expQ.pop_front(); total++;
    if (bus.BusA !== e) begin bad++; $display("FAIL retire_data got=%h want=%h", bus.BusA, e); end
    total++;
    if (bus.BusyA !== 1'b0) begin bad++; $display("FAIL retire_clear got=%b want=1'b0", bus.BusyA); end
    bus.RegWr0 = 1; bus.RW0 = 5'd9; bus.BusW0 = 64'h6; bus.Rsv = 1; bus.RsvAddr = 5'd9;
    @(negedge Clk) idle(); bus.RA = 5'd9; #1;
    total++;
    if (bus.BusyA !== 1'b1) begin bad++; $display("FAIL set_wins got=%b want=1", bus.BusyA); end
    bus.RegWr0 = 1; bus.RW0 = 5'd9; bus.BusW0 = 64'h7; bus.Rsv = 1; bus.RsvAddr = 5'd9; #1;
    total++;
    if (bus.RsvOk !== 1'b0) begin bad++; $display("FAIL busy_rsv_denied got=%b want=0", bus.RsvOk); end
    @(negedge Clk) idle(); bus.RA = 5'd9; #1;
    total++;
    if (bus.BusyA !== 1'b0) begin bad++; $display("FAIL denied_then_clear got=%b want=0", bus.BusyA); end
  endtask

  task automatic test_bypass;
    logic [63:0] e;
    @(negedge Clk) idle(); bus.RA = 5'd4; bus.RB = 5'd4;
    bus.RegWr1 = 1; bus.RW1 = 5'd4; bus.BusW1 = 64'hCAFE;
    bus.RegWr0 = 1; bus.RW0 = 5'd4; bus.BusW0 = 64'hBEEF;
`ifdef REGFILE_BYPASS_EN
    expQ.push_back(64'hCAFE); expQ.push_back(64'hCAFE);
`else
    expQ.push_back(64'd0); expQ.push_back(64'd0);
`endif
    expQ.push_back(64'hCAFE);
    #1;
    e = expQ.pop_front(); total++;
    if (bus.BusA !== e) begin bad++; $display("FAIL bypass_a got=%h want=%h", bus.BusA, e); end
    e = expQ.pop_front(); total++;
    if (bus.BusB !== e) begin bad++; $display("FAIL bypass_b got=%h want=%h", bus.BusB, e); end
    @(negedge Clk) idle(); bus.RA = 5'd4; #1;
    e = expQ.pop_front(); total++;
    if (bus.BusA !== e) begin bad++; $display("FAIL bypass_after_edge got=%h want=%h", bus.BusA, e); end
  endtask

  task automatic test_sweep;
    logic [31:0] mdl [16];
    logic        busyM [16];
    logic        w0, w1, ok;
    logic [3:0]  a0, a1;
    exp_t        x, y;
    for (int i = 0; i < 16; i++) begin mdl[i] = '0; busyM[i] = 0; end
    @(negedge Clk) idle(); Rst_n = 0;
    @(negedge Clk) Rst_n = 1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge Clk);
      bus2.RA = 4'($urandom_range(0, 15)); bus2.RB = 4'($urandom_range(0, 15));
      bus2.RegWr0 = 1'($urandom_range(0, 1)); bus2.RegWr1 = 1'($urandom_range(0, 1));
      bus2.RW0 = 4'($urandom_range(0, 15)); bus2.RW1 = (c % 7 == 0) ? bus2.RW0 : 4'($urandom_range(0, 15));
      bus2.BusW0 = $urandom; bus2.BusW1 = $urandom;
      bus2.Rsv = ($urandom_range(0, 2) == 0); bus2.RsvAddr = 4'($urandom_range(0, 15));
      w0 = bus2.RegWr0 && bus2.RW0 != 4'd15; w1 = bus2.RegWr1 && bus2.RW1 != 4'd15;
      a0 = bus2.RW0; a1 = bus2.RW1;
      x.a = bus2.RA == 4'd15 ? 32'd0 : mdl[bus2.RA];
      x.b = bus2.RB == 4'd15 ? 32'd0 : mdl[bus2.RB];
`ifdef REGFILE_BYPASS_EN
      if (bus2.RA != 4'd15) x.a = (w1 && a1 == bus2.RA) ? bus2.BusW1 : (w0 && a0 == bus2.RA) ? bus2.BusW0 : x.a;
      if (bus2.RB != 4'd15) x.b = (w1 && a1 == bus2.RB) ? bus2.BusW1 : (w0 && a0 == bus2.RB) ? bus2.BusW0 : x.b;
`endif
      x.ba = busyM[bus2.RA]; x.bb = busyM[bus2.RB];
      ok = bus2.Rsv && !busyM[bus2.RsvAddr] && bus2.RsvAddr != 4'd15;
      x.ok = ok;
      swQ.push_back(x);
      if (w0) begin mdl[a0] = bus2.BusW0; busyM[a0] = 0; end
      if (w1) begin mdl[a1] = bus2.BusW1; busyM[a1] = 0; end
      if (ok) busyM[bus2.RsvAddr] = 1;
      #1;
      y = swQ.pop_front();
      total++;
      if (bus2.BusA !== y.a || bus2.BusB !== y.b || bus2.BusyA !== y.ba || bus2.BusyB !== y.bb || bus2.RsvOk !== y.ok) begin
        bad++;
        $display("FAIL sweep c=%0d got a=%h b=%h ba=%b bb=%b ok=%b want a=%h b=%h ba=%b bb=%b ok=%b",
                 c, bus2.BusA, bus2.BusB, bus2.BusyA, bus2.BusyB, bus2.RsvOk, y.a, y.b, y.ba, y.bb, y.ok);
      end
    end
    @(negedge Clk) idle();
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_dual_write();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the single-cycle datapath and its pipelined successor: 2 read ports, 2 write ports, a hardwired zero register, and a per-register busy scoreboard for in-flight writebacks. It sits between decode (RA/RB) and writeback, replacing the 32x64 single-write file. It adds asynchronous reset of all state, write-port collision priority, reservation tracking, and optional write-to-read bypass.

## Interface
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 2**ADDR_W-1, index of the hardwired-zero register (reads 0, writes ignored)
- Clk  input  1  clock; all state updates on rising edge
- Rst_n  input  1  asynchronous, active-low reset
- RA, RB  input  ADDR_W  read addresses
- BusA, BusB  output  DATA_W  read data for RA, RB (combinational)
- BusyA, BusyB  output  1  scoreboard busy bit of RA, RB (combinational)
- RegWr0, RegWr1  input  1  write enables, port 0 / port 1
- RW0, RW1  input  ADDR_W  write addresses
- BusW0, BusW1  input  DATA_W  write data
- Rsv  input  1  reserve request: mark RsvAddr busy
- RsvAddr  input  ADDR_W  register to reserve
- RsvOk  output  1  combinational: Rsv granted this cycle (RsvAddr not busy, not ZERO_REG)

## Operation
- Reads: BusA = reg[RA], BusB = reg[RB]; address ZERO_REG always returns 0.
- Writes: on rising Clk, if RegWrN and RWN != ZERO_REG, reg[RWN] <= BusWN.
- Collision: RegWr0 and RegWr1 both set with RW0 == RW1 -> port 1 wins; port 0's data is discarded.
- Scoreboard: busy[DEPTH] bits, all 0 after reset; busy[ZERO_REG] is constant 0.
  - Set: Rsv && RsvOk -> busy[RsvAddr] <= 1 on rising edge.
  - Clear: any committed write to address X clears busy[X] on the same edge.
  - Same-edge clear and set on one address: set wins (a new reservation follows the retiring write).
  - Rsv to an already-busy address: RsvOk = 0, no state change; the requester stalls.
- BusyA/BusyB reflect busy[RA]/busy[RB] before the edge. They are combinational and registered-state based; no bypass is applied to them.
- Reset (Rst_n low, at any time including mid-write): all registers clear to 0 and all busy bits to 0 immediately. Writes and reservations are ignored while Rst_n is low. The first edge after Rst_n rises is a normal edge.

## Timing
- Read latency 0 cycles, combinational from RA/RB and register state.
- Write latency 1 edge: data written at edge N is visible on BusA/BusB after edge N (without bypass).
- Reset values: BusA/BusB = 0, BusyA/BusyB = 0, RsvOk = Rsv && (RsvAddr != ZERO_REG).
- No multicycle paths. Write-to-read forwarding exists only when the configuration macro below is defined.

## Configuration
- REGFILE_BYPASS_EN defined: if RegWrN is set, RWN == RA (or RB), and RWN != ZERO_REG, BusA (or BusB) returns BusWN in the same cycle, before the edge. When both ports match, port 1 is forwarded, consistent with the collision rule. This provides same-cycle write/read for the pipelined datapath.
- Not defined: reads return stored contents only. The new value appears after the write edge.

## Test plan
- Reset: write 0xDEAD to r3, pulse Rst_n low mid-cycle -> BusA(RA=3) = 0 immediately, BusyA = 0, and no write occurs at the following edge while Rst_n is low.
- Zero register: RegWr0=1, RW0=31, BusW0=0x1234, edge -> BusA(RA=31) = 0. Rsv with RsvAddr=31 -> RsvOk = 0.
- Dual write / collision: same edge, W0 writes r5=0x11 and W1 writes r6=0x22 -> r5=0x11, r6=0x22. Then W0 r7=0xAA and W1 r7=0xBB -> r7=0xBB.
- Scoreboard: Rsv r9 -> BusyA(RA=9)=1. A second Rsv r9 -> RsvOk=0. Write r9=0x5 -> busy clear after that edge. Write r9 with Rsv r9 on the same edge -> busy stays 1.
- Bypass (REGFILE_BYPASS_EN): RegWr1=1, RW1=4, BusW1=0xCAFE, RA=4 -> BusA=0xCAFE before the edge. Without the macro, BusA holds the old value until after the edge.
- Parameter sweep: DATA_W=32, ADDR_W=4 -> ZERO_REG=15. Randomised writes and reads checked against a reference model over 1000 cycles.
